alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the team's combinational 4-bit ALU.
- Datapath width is configurable. The block adds status flags, a signed set-less-than op, and an optional multi-cycle shift-add multiplier.
- Operands enter through a valid/ready input channel. One registered result leaves through a valid/ready output channel.
- Sits between the register-file read stage and writeback in the course CPU datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range is 2 or more.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and op are presented.
- in_ready  output  1  block accepts operands this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Op  input  3  operation select.
- out_valid  output  1  S and flags are valid.
- out_ready  input  1  consumer takes the result this cycle.
- S  output  WIDTH  result.
- flags  output  4  {Z,N,C,V}.

Behaviour:
- Reset: one clock; rst_n asynchronous, active-low.
  - While rst_n=0: state=IDLE, out_valid=0, S=0, flags=0, multiplier registers cleared.
  - in_ready is 0 during reset.
  - Reset mid-multiply abandons the operation; no result is produced.
- Op encoding:
  - 000 A&B
  - 001 A|B
  - 010 A+B
  - 011 MUL (optional)
  - 100 A&~B
  - 101 A|~B
  - 110 A-B, computed as A+~B+1
  - 111 SLT
- SLT result: zero-extended 1 if A<B signed, i.e. (diff MSB xor V) of A-B; otherwise 0.
- Accept rule: a transfer occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - A result is therefore never overwritten before it is consumed.
- Single-cycle ops (all except MUL):
  - Accepted on edge N; S, flags and out_valid=1 are registered on the same edge.
  - Visible in cycle N+1, i.e. latency 1.
  - Back-to-back throughput is 1 per cycle when out_ready stays high.
- Output hold:
  - out_valid stays 1 and S/flags stay stable until out_ready=1.
  - On a consume edge with no new accept, out_valid drops to 0.
  - A consume and a new accept on the same edge load the new result; out_valid stays 1.
- Flags:
  - Z = (S==0); N = S[WIDTH-1].
  - ADD: C = carry out of bit WIDTH-1; V = signed overflow.
  - SUB/SLT: C = carry out of A+~B+1, where 1 means no borrow; V = signed overflow of A-B. Z/N still reflect S.
  - Logic ops: C=0, V=0.
- States:
  - IDLE: accepts as above.
  - MUL: entered on accepting Op=011. Shift-add, one multiplier bit per cycle, for exactly WIDTH cycles, with in_ready=0.
  - MUL exit: after the last step, the result registers load and out_valid=1; return to IDLE.
  - MUL holds in_ready=0; new operands wait in the producer.
- MUL result: S = low WIDTH bits of the unsigned product. C=1 if the upper WIDTH bits are nonzero; V=0. Z/N from S.
- MUL latency: WIDTH+1 cycles from the accept edge to out_valid.
- Wrap-around: ADD/SUB/MUL wrap modulo 2^WIDTH; overflow is reported only through C/V.

Optional Feature:
- Macro ALU_PIPE_MUL_EN.
- Defined: MUL state and shift-add datapath are present, as described above.
- Undefined:
  - No MUL state or multiplier registers.
  - Op=011 is treated as a single-cycle op returning S=0, flags={1,0,0,0}, latency 1.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> out_valid=0, S=0, flags=0 immediately; in_ready=1 first cycle after release.
- WIDTH=8 ADD 0x7F+0x01 -> S=0x80, flags Z0 N1 C0 V1. ADD 0xFF+0x01 -> S=0x00, Z1 N0 C1 V0.
- WIDTH=8 SUB 0x03-0x05 -> S=0xFE, N1 C0. SLT 0x80,0x01 -> S=0x01. SLT 0x01,0x80 -> S=0x00.
- Backpressure: two back-to-back ADDs with out_ready=0 for 3 cycles:
  - first result held stable, in_ready=0;
  - when out_ready rises, second result follows the next cycle, no loss or duplication.
- With ALU_PIPE_MUL_EN, WIDTH=8:
  - MUL 0x10*0x11 -> out_valid exactly 9 cycles after accept, S=0x10, C=1, in_ready=0 throughout.
  - Reset during cycle 4 of MUL -> no result emitted.
- Without ALU_PIPE_MUL_EN: Op=011 with any operands -> S=0x00, flags=4'b1000, latency 1.

Source files
------------

// File: rtl/alu_pipe_if.sv
// Valid/ready operand and result channels of alu_pipe.
// master drives operands and consumes results; slave is the ALU.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       Op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic [3:0]       flags;

  modport master (
    output in_valid, A, B, Op, out_ready,
    input  in_ready, out_valid, S, flags
  );

  modport slave (
    input  in_valid, A, B, Op, out_ready,
    output in_ready, out_valid, S, flags
  );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result and {Z,N,C,V} flags.
// Define ALU_PIPE_MUL_EN to add the WIDTH-cycle shift-add multiplier on Op=011.
module alu_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);
  localparam logic [2:0] OpMul = 3'b011;

  logic             in_ready;
  logic             accept;
  logic             consume;
  logic             load_alu;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_s;
  logic             arith;
  logic             alu_c;
  logic             alu_v;
  logic             slt;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [3:0]       flags_q, flags_d;

  assign accept  = bus.in_valid && in_ready;
  assign consume = out_valid_q && bus.out_ready;

  // Op[2] selects ~B; subtract-style ops (110, 111) also inject the +1.
  always_comb begin
    b_op  = bus.Op[2] ? ~bus.B : bus.B;
    sum   = {1'b0, bus.A} + {1'b0, b_op} + {{WIDTH{1'b0}}, bus.Op[2] & bus.Op[1]};
    arith = bus.Op[1] & (bus.Op[2] | ~bus.Op[0]);
    alu_v = arith & (bus.A[WIDTH-1] == b_op[WIDTH-1]) & (sum[WIDTH-1] != bus.A[WIDTH-1]);
    alu_c = arith & sum[WIDTH];
    slt   = sum[WIDTH-1] ^ alu_v;
    alu_s = '0;
    case (bus.Op[1:0])
      2'b00:   alu_s = bus.A & b_op;
      2'b01:   alu_s = bus.A | b_op;
      2'b10:   alu_s = sum[WIDTH-1:0];
      default: alu_s = bus.Op[2] ? WIDTH'(slt) : '0;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     mplier_q;
  logic [CntW-1:0]      cnt_q;
  logic                 start_mul;
  logic                 mul_done;

  assign start_mul = accept && (bus.Op == OpMul);
  assign load_alu  = accept && !start_mul;
  assign mul_done  = (state_q == StMul) && (cnt_q == CntW'(WIDTH - 1));
  // Last step's sum feeds the result registers directly, saving a cycle.
  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_mul) state_d = StMul;
      StMul:   if (mul_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = rst_n && (state_q == StIdle) && (!out_valid_q || bus.out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start_mul) begin
      mcand_q  <= {{WIDTH{1'b0}}, bus.A};
      acc_q    <= '0;
      mplier_q <= bus.B;
      cnt_q    <= '0;
    end else if (state_q == StMul) begin
      mcand_q  <= mcand_q << 1;
      acc_q    <= acc_step;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end
`else
  assign load_alu = accept;

  always_comb begin
    in_ready = rst_n && (!out_valid_q || bus.out_ready);
  end
`endif

  always_comb begin
    out_valid_d = out_valid_q & ~consume;
    s_d         = s_q;
    flags_d     = flags_q;
    if (load_alu) begin
      out_valid_d = 1'b1;
      s_d         = alu_s;
      flags_d     = {(alu_s == '0), alu_s[WIDTH-1], alu_c, alu_v};
    end
`ifdef ALU_PIPE_MUL_EN
    if (mul_done) begin
      out_valid_d = 1'b1;
      s_d         = acc_step[WIDTH-1:0];
      flags_d     = {(acc_step[WIDTH-1:0] == '0), acc_step[WIDTH-1],
                     |acc_step[2*WIDTH-1:WIDTH], 1'b0};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.S         = s_q;
  assign bus.flags     = flags_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=8.
// Also covers the multiplier when ALU_PIPE_MUL_EN is defined.
module tb_alu_pipe;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  alu_pipe_if #(.WIDTH(8)) bus ();

  alu_pipe #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one operation for exactly one edge, then withdraw it.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.Op       = op;
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst0_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.S !== 8'h00) begin errors++; $display("FAIL rst0_s: got %h want 00", bus.S); end
    checks++; if (bus.flags !== 4'h0) begin errors++; $display("FAIL rst0_flags: got %b want 0000", bus.flags); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst0_ready: got %b want 0", bus.in_ready); end
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst0_release_ready: got %b want 1", bus.in_ready); end
    // Mid-stream: hold a result, then reset between edges.
    bus.out_ready = 1'b0;
    issue(3'b010, 8'h12, 8'h34);
    checks++; if (bus.S !== 8'h46) begin errors++; $display("FAIL rst_pre_s: got %h want 46", bus.S); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.S !== 8'h00) begin errors++; $display("FAIL rst_mid_s: got %h want 00", bus.S); end
    checks++; if (bus.flags !== 4'h0) begin errors++; $display("FAIL rst_mid_flags: got %b want 0000", bus.flags); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b want 0", bus.in_ready); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_release_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_release_valid: got %b want 0", bus.out_valid); end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_add;
    issue(3'b010, 8'h7F, 8'h01);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add1_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.S !== 8'h80) begin errors++; $display("FAIL add1_s: got %h want 80", bus.S); end
    checks++; if (bus.flags !== 4'b0101) begin errors++; $display("FAIL add1_flags: got %b want 0101", bus.flags); end
    issue(3'b010, 8'hFF, 8'h01);
    checks++; if (bus.S !== 8'h00) begin errors++; $display("FAIL add2_s: got %h want 00", bus.S); end
    checks++; if (bus.flags !== 4'b1010) begin errors++; $display("FAIL add2_flags: got %b want 1010", bus.flags); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_drain_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_sub_slt;
    issue(3'b110, 8'h03, 8'h05);
    checks++; if (bus.S !== 8'hFE) begin errors++; $display("FAIL sub_s: got %h want fe", bus.S); end
    checks++; if (bus.flags !== 4'b0100) begin errors++; $display("FAIL sub_flags: got %b want 0100", bus.flags); end
    issue(3'b111, 8'h80, 8'h01);
    checks++; if (bus.S !== 8'h01) begin errors++; $display("FAIL slt1_s: got %h want 01", bus.S); end
    checks++; if (bus.flags !== 4'b0011) begin errors++; $display("FAIL slt1_flags: got %b want 0011", bus.flags); end
    issue(3'b111, 8'h01, 8'h80);
    checks++; if (bus.S !== 8'h00) begin errors++; $display("FAIL slt2_s: got %h want 00", bus.S); end
    checks++; if (bus.flags !== 4'b1001) begin errors++; $display("FAIL slt2_flags: got %b want 1001", bus.flags); end
  endtask

  task automatic test_logic;
    issue(3'b000, 8'hF0, 8'h3C);
    checks++; if ({bus.S, bus.flags} !== {8'h30, 4'b0000}) begin errors++; $display("FAIL and: got %h/%b want 30/0000", bus.S, bus.flags); end
    issue(3'b001, 8'h0F, 8'h80);
    checks++; if ({bus.S, bus.flags} !== {8'h8F, 4'b0100}) begin errors++; $display("FAIL or: got %h/%b want 8f/0100", bus.S, bus.flags); end
    issue(3'b100, 8'hFF, 8'h0F);
    checks++; if ({bus.S, bus.flags} !== {8'hF0, 4'b0100}) begin errors++; $display("FAIL andn: got %h/%b want f0/0100", bus.S, bus.flags); end
    issue(3'b101, 8'h00, 8'hFF);
    checks++; if ({bus.S, bus.flags} !== {8'h00, 4'b1000}) begin errors++; $display("FAIL orn: got %h/%b want 00/1000", bus.S, bus.flags); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] a_v [3];
    logic [7:0] b_v [3];
    logic [7:0] s_v [3];
    a_v = '{8'h01, 8'h20, 8'hF0};
    b_v = '{8'h02, 8'h22, 8'h20};
    s_v = '{8'h03, 8'h42, 8'h10};
    bus.out_ready = 1'b1;
    bus.Op        = 3'b010;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.A = a_v[i];
      bus.B = b_v[i];
      @(posedge clk); #1;
      checks++; if ({bus.out_valid, bus.S} !== {1'b1, s_v[i]}) begin errors++; $display("FAIL b2b_%0d: got %b/%h want 1/%h", i, bus.out_valid, bus.S, s_v[i]); end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    bus.out_ready = 1'b0;
    issue(3'b010, 8'h01, 8'h02);
    checks++; if ({bus.out_valid, bus.S, bus.in_ready} !== {1'b1, 8'h03, 1'b0}) begin errors++; $display("FAIL bp_first: got %b/%h/%b want 1/03/0", bus.out_valid, bus.S, bus.in_ready); end
    bus.Op = 3'b010; bus.A = 8'h10; bus.B = 8'h20; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if ({bus.out_valid, bus.S, bus.in_ready} !== {1'b1, 8'h03, 1'b0}) begin errors++; $display("FAIL bp_hold_%0d: got %b/%h/%b want 1/03/0", i, bus.out_valid, bus.S, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if ({bus.out_valid, bus.S} !== {1'b1, 8'h30}) begin errors++; $display("FAIL bp_second: got %b/%h want 1/30", bus.out_valid, bus.S); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b want 0", bus.out_valid); end
  endtask

`ifdef ALU_PIPE_MUL_EN
  task automatic test_mul;
    int  lat;
    logic seen;
    bus.out_ready = 1'b1;
    issue(3'b011, 8'h10, 8'h11);
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.out_valid) begin
        seen = 1'b1;
      end else begin
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mul_busy_ready_%0d: got %b want 0", lat, bus.in_ready); end
        @(posedge clk); #1;
        lat++;
      end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mul_timeout: got %b want 1", seen); end
    checks++; if (lat != 9) begin errors++; $display("FAIL mul_latency: got %0d want 9", lat); end
    checks++; if ({bus.S, bus.flags} !== {8'h10, 4'b0010}) begin errors++; $display("FAIL mul_result: got %h/%b want 10/0010", bus.S, bus.flags); end
    @(posedge clk); #1;
    // Abandon a multiply in its fourth cycle.
    issue(3'b011, 8'h03, 8'h05);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mul_reset_no_result: got %b want 0", seen); end
  endtask
`else
  task automatic test_op3;
    bus.out_ready = 1'b1;
    issue(3'b010, 8'hFF, 8'h01);
    issue(3'b011, 8'h05, 8'h07);
    checks++; if ({bus.out_valid, bus.S, bus.flags} !== {1'b1, 8'h00, 4'b1000}) begin errors++; $display("FAIL op3_a: got %b/%h/%b want 1/00/1000", bus.out_valid, bus.S, bus.flags); end
    issue(3'b011, 8'hFF, 8'hFF);
    checks++; if ({bus.out_valid, bus.S, bus.flags} !== {1'b1, 8'h00, 4'b1000}) begin errors++; $display("FAIL op3_b: got %b/%h/%b want 1/00/1000", bus.out_valid, bus.S, bus.flags); end
  endtask
`endif

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.A         = '0;
    bus.B         = '0;
    bus.Op        = '0;
    #1;
    test_reset();
    test_add();
    test_sub_slt();
    test_logic();
    test_back_to_back();
    test_backpressure();
`ifdef ALU_PIPE_MUL_EN
    test_mul();
`else
    test_op3();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
